// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns a debounced, clk-synchronous key level into one-cycle event strobes:
//   press, release, click (short press), long press, and auto-repeat.
//
// Parameters
//   ACTIVE_LEVEL  : btn_level value that means "pressed" (0 = active-low key)
//   LONG_CYCLES   : cycles from press_pulse to long_pulse (>= 2)
//   REPEAT_CYCLES : auto-repeat period after long_pulse (>= 1)
//
// Ports
//   clk           : system clock, rising edge
//   as_reset_n    : asynchronous active-low reset
//   btn_level     : debounced key level
//   press_pulse   : one cycle on accepted press
//   release_pulse : one cycle on release of an accepted press
//   click_pulse   : one cycle on release before long_pulse
//   long_pulse    : one cycle when hold reaches LONG_CYCLES
//   repeat_pulse  : one cycle every REPEAT_CYCLES while held after long_pulse
//   step_pulse    : press_pulse | repeat_pulse
//   held          : high while an accepted press is in progress
module button_event_decoder #(
  parameter int unsigned ACTIVE_LEVEL  = 0,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic as_reset_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic held
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] LONG_TC   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
  localparam logic          ACT_LVL   = ACTIVE_LEVEL[0];

  typedef enum logic [1:0] {
    DISARMED,
    IDLE,
    PRESSED,
    REPEAT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          act;
  logic          press_nx, release_nx, click_nx, long_nx, repeat_nx;
  logic          step_nx, held_nx;

  assign act = (btn_level == ACT_LVL);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    click_nx   = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;

    case (state)
      // Wait for the key to be seen released once, so a key level that
      // reads "pressed" straight out of reset is never taken as a press.
      DISARMED: begin
        if (!act) begin
          state_nx = IDLE;
        end
      end

      IDLE: begin
        if (act) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end
      end

      // Release is tested first so it wins over a coincident terminal count.
      PRESSED: begin
        if (!act) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
          click_nx   = 1'b1;
        end else if (cnt == LONG_TC) begin
          state_nx = REPEAT;
          cnt_nx   = '0;
          long_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      REPEAT: begin
        if (!act) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else if (cnt == REPEAT_TC) begin
          cnt_nx    = '0;
          repeat_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end

      default: begin
        state_nx = DISARMED;
        cnt_nx   = '0;
      end
    endcase

    step_nx = press_nx | repeat_nx;
    held_nx = (state_nx == PRESSED) || (state_nx == REPEAT);
  end

  always_ff @(posedge clk or negedge as_reset_n) begin
    if (!as_reset_n) begin
      state         <= DISARMED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      step_pulse    <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      click_pulse   <= click_nx;
      long_pulse    <= long_nx;
      repeat_pulse  <= repeat_nx;
      step_pulse    <= step_nx;
      held          <= held_nx;
    end
  end

endmodule
